// File: rtl/prbs_pkg.sv
// Shared types for the PRBS receive checker.
package prbs_pkg;

  // Lock FSM states: fill the local register, verify predictions, then track.
  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } prbs_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating statistics counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  // Count up, hold at all-ones; a clear drops any same-cycle increment.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i)
      cnt_o <= '0;
    else if (inc_i && (cnt_o != '1))
      cnt_o <= cnt_o + WIDTH'(1);
  end

endmodule

// File: rtl/prbs_checker.sv
// Serial PRBS checker. Self-synchronises by loading DATA_WIDTH received bits,
// then free-runs its own LFSR and compares every valid bit against it.
// An all-zero input stream leaves the register at zero and predicts zeros, so
// it reports lock on a dead link; this is a known, undetected limitation.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int LOCK_THRESH = 32,
  parameter int WIN_LEN     = 256,
  parameter int ERR_LIMIT   = 8,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic [DATA_WIDTH-1:0] poly_i,
  input  logic                  valid_i,
  input  logic                  data_i,
  output logic                  locked_o,
  output logic                  err_o,
  output logic [CNT_WIDTH-1:0]  err_cnt_o,
  output logic [CNT_WIDTH-1:0]  bit_cnt_o
);

  localparam int LCW = $clog2(DATA_WIDTH + 1);
  localparam int GCW = $clog2(LOCK_THRESH + 1);
  localparam int WCW = $clog2(WIN_LEN + 1);
  localparam int ECW = $clog2(ERR_LIMIT + 1);

  // Terminal values: the counter holds N-1 while the N-th event is in flight.
  localparam logic [LCW-1:0] LOAD_LAST = LCW'(DATA_WIDTH - 1);
  localparam logic [GCW-1:0] GOOD_LAST = GCW'(LOCK_THRESH - 1);
  localparam logic [WCW-1:0] WIN_LAST  = WCW'(WIN_LEN - 1);
  localparam logic [ECW-1:0] ERR_LAST  = ECW'(ERR_LIMIT - 1);

  prbs_state_t           state_q, state_d;
  logic [DATA_WIDTH-1:0] lfsr_q, lfsr_d;
  logic [LCW-1:0]        load_q, load_d;
  logic [GCW-1:0]        good_q, good_d;
  logic [WCW-1:0]        win_q, win_d;
  logic [ECW-1:0]        werr_q, werr_d;
  logic                  err_q, locked_q;
  logic                  pred, mism, err_inc, bit_inc;

  assign pred = ^(lfsr_q & poly_i);
  assign mism = data_i ^ pred;

  // Next-state, predictor advance and window bookkeeping; idle when !valid_i.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    load_d  = load_q;
    good_d  = good_q;
    win_d   = win_q;
    werr_d  = werr_q;
    err_inc = 1'b0;
    bit_inc = 1'b0;
    if (valid_i) begin
      case (state_q)
        LOAD: begin
          lfsr_d = {lfsr_q[DATA_WIDTH-2:0], data_i};
          if (load_q == LOAD_LAST) begin
            state_d = VERIFY;
            load_d  = '0;
            good_d  = '0;
          end else begin
            load_d = load_q + LCW'(1);
          end
        end
        VERIFY: begin
          // Only the prediction is shifted in, so a bad bit cannot poison it.
          lfsr_d = {lfsr_q[DATA_WIDTH-2:0], pred};
          if (mism) begin
            state_d = LOAD;
            load_d  = '0;
          end else if (good_q == GOOD_LAST) begin
            state_d = LOCKED;
            win_d   = '0;
            werr_d  = '0;
          end else begin
            good_d = good_q + GCW'(1);
          end
        end
        LOCKED: begin
          lfsr_d  = {lfsr_q[DATA_WIDTH-2:0], pred};
          bit_inc = 1'b1;
          err_inc = mism;
          // Loss of lock wins over the end-of-window reset on the same bit.
          if (mism && (werr_q == ERR_LAST)) begin
            state_d = LOAD;
            load_d  = '0;
          end else if (win_q == WIN_LAST) begin
            win_d  = '0;
            werr_d = '0;
          end else begin
            win_d  = win_q + WCW'(1);
            werr_d = werr_q + ECW'(mism);
          end
        end
        default: state_d = LOAD;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= LOAD;
      lfsr_q   <= '0;
      load_q   <= '0;
      good_q   <= '0;
      win_q    <= '0;
      werr_q   <= '0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      load_q   <= load_d;
      good_q   <= good_d;
      win_q    <= win_d;
      werr_q   <= werr_d;
      err_q    <= err_inc;
      locked_q <= (state_d == LOCKED);
    end
  end

  assign err_o    = err_q;
  assign locked_o = locked_q;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_err_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (clr_i),
    .inc_i (err_inc),
    .cnt_o (err_cnt_o)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_bit_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (clr_i),
    .inc_i (bit_inc),
    .cnt_o (bit_cnt_o)
  );

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: default instance plus an 8-bit-counter
// instance with a large error limit, both fed from a reference LFSR stream.
module tb_prbs_checker;

  logic        clk_i = 1'b0;
  logic        rst_i, clr_i, valid_i, data_i;
  logic [15:0] poly_i = 16'hB400;

  logic        locked_o, err_o;
  logic [31:0] err_cnt_o, bit_cnt_o;
  logic        locked2, err2;
  logic [7:0]  ecnt2, bcnt2;

  prbs_checker dut (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i), .poly_i(poly_i),
    .valid_i(valid_i), .data_i(data_i), .locked_o(locked_o), .err_o(err_o),
    .err_cnt_o(err_cnt_o), .bit_cnt_o(bit_cnt_o)
  );

  prbs_checker #(.CNT_WIDTH(8), .ERR_LIMIT(1000)) dut8 (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i), .poly_i(poly_i),
    .valid_i(valid_i), .data_i(data_i), .locked_o(locked2), .err_o(err2),
    .err_cnt_o(ecnt2), .bit_cnt_o(bcnt2)
  );

  always #5 clk_i = ~clk_i;

  int          checks = 0, errors = 0, cyc = 0;
  int          exp_q[$];
  logic [15:0] gen = 16'hACE1;
  bit          exp_lock = 1'b0;
  int          exp_bits = 0, exp_errs = 0, lb = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One cycle of stimulus; a valid bit advances the reference generator.
  task automatic drive_bit(input bit inv, input bit v, input bit c);
    @(negedge clk_i);
    valid_i = v;
    clr_i   = c;
    if (v) begin
      gen    = {gen[14:0], ^(gen & poly_i)};
      data_i = gen[0] ^ inv;
    end else begin
      data_i = 1'($urandom);
    end
    if (v && exp_lock) begin
      if (inv) exp_q.push_back(cyc + 1);
      lb++;
      if (c) begin exp_bits = 0; exp_errs = 0; end
      else begin exp_bits++; if (inv) exp_errs++; end
    end else if (c) begin
      exp_bits = 0; exp_errs = 0;
    end
    @(posedge clk_i);
    #1;
    clr_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i   = 1'b1;
    valid_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_i    = 1'b0;
    exp_lock = 1'b0;
    exp_bits = 0;
    exp_errs = 0;
  endtask

  // err_o scoreboard: every cycle compared against the queued pulse cycles.
  initial forever begin
    bit exp_e;
    @(posedge clk_i);
    cyc++;
    #1;
    while (exp_q.size() > 0 && exp_q[0] < cyc) void'(exp_q.pop_front());
    exp_e = (exp_q.size() > 0 && exp_q[0] == cyc);
    if (exp_e) void'(exp_q.pop_front());
    chk("err_o", {31'd0, err_o}, {31'd0, exp_e});
  end

  initial begin
    int nv;
    bit v;
    rst_i = 1'b1; clr_i = 1'b0; valid_i = 1'b0; data_i = 1'b0;

    // Reset state
    do_reset();
    chk("rst_locked", locked_o, 0);
    chk("rst_errcnt", err_cnt_o, 0);
    chk("rst_bitcnt", bit_cnt_o, 0);
    chk("rst_errcnt8", ecnt2, 0);

    // Continuous stream: lock after 48 bits, then 10000 clean bits
    repeat (47) drive_bit(0, 1, 0);
    chk("lock_47", locked_o, 0);
    drive_bit(0, 1, 0);
    chk("lock_48", locked_o, 1);
    exp_lock = 1; lb = 0;
    repeat (10000) drive_bit(0, 1, 0);
    chk("clean_errcnt", err_cnt_o, 0);
    chk("clean_bitcnt", bit_cnt_o, 10000);
    chk("clean_locked", locked_o, 1);

    // Mid-operation reset, then ~50% valid: lock after exactly 48 valid bits
    do_reset();
    chk("rst2_locked", locked_o, 0);
    chk("rst2_bitcnt", bit_cnt_o, 0);
    nv = 0;
    while (nv < 47) begin
      v = 1'($urandom_range(0, 1));
      drive_bit(0, v, 0);
      if (v) nv++;
      chk("rnd_unlocked", locked_o, 0);
    end
    repeat (5) drive_bit(0, 0, 0);
    chk("hold_47", locked_o, 0);
    drive_bit(0, 1, 0);
    chk("lock_rnd48", locked_o, 1);
    exp_lock = 1; lb = 0;
    repeat (5) drive_bit(0, 0, 0);
    chk("hold_bitcnt", bit_cnt_o, 0);
    chk("hold_locked", locked_o, 1);
    drive_bit(0, 1, 0);
    chk("bitcnt_1", bit_cnt_o, 1);
    repeat (200) drive_bit(0, 1'($urandom_range(0, 1)), 0);
    chk("rnd_bitcnt", bit_cnt_o, exp_bits);

    // Single inverted bit while locked
    drive_bit(1, 1, 0);
    chk("single_errcnt", err_cnt_o, 1);
    chk("single_locked", locked_o, 1);
    repeat (300) drive_bit(0, 1, 0);
    chk("single_after_errcnt", err_cnt_o, 1);
    chk("single_after_bitcnt", bit_cnt_o, exp_bits);

    // Eight errors inside one window: lock lost on the 8th
    while (lb % 256 != 0) drive_bit(0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      repeat (3) drive_bit(0, 1, 0);
      drive_bit(1, 1, 0);
      if (i == 6) chk("err7_locked", locked_o, 1);
      if (i == 7) begin
        exp_lock = 0;
        chk("err8_unlocked", locked_o, 0);
      end
    end
    chk("err8_errcnt", err_cnt_o, 9);
    chk("err8_bitcnt", bit_cnt_o, exp_bits);
    repeat (47) drive_bit(0, 1, 0);
    chk("relock_47", locked_o, 0);
    drive_bit(0, 1, 0);
    chk("relock_48", locked_o, 1);
    exp_lock = 1; lb = 0;
    chk("relock_bitcnt", bit_cnt_o, exp_bits);

    // Clear keeps lock; 7 errors closing a window, 1 opening the next
    drive_bit(0, 0, 1);
    chk("clr_errcnt", err_cnt_o, 0);
    chk("clr_bitcnt", bit_cnt_o, 0);
    chk("clr_locked", locked_o, 1);
    while (lb % 256 != 249) drive_bit(0, 1, 0);
    repeat (7) drive_bit(1, 1, 0);
    chk("win7_locked", locked_o, 1);
    drive_bit(1, 1, 0);
    chk("win_next_locked", locked_o, 1);
    chk("win_errcnt", err_cnt_o, 8);
    repeat (20) drive_bit(0, 1, 0);
    chk("win_bitcnt", bit_cnt_o, exp_bits);

    // Error on bit 20 (VERIFY): back to LOAD, 48 more clean bits to lock
    do_reset();
    chk("rst3_errcnt", err_cnt_o, 0);
    repeat (19) drive_bit(0, 1, 0);
    drive_bit(1, 1, 0);
    repeat (47) drive_bit(0, 1, 0);
    chk("verify_err_47", locked_o, 0);
    drive_bit(0, 1, 0);
    chk("verify_err_48", locked_o, 1);
    exp_lock = 1; lb = 0;
    chk("verify_errcnt", err_cnt_o, 0);
    chk("verify_errcnt8", ecnt2, 0);

    // 8-bit counters saturate under continuous errors
    chk("sat_locked8", locked2, 1);
    for (int i = 0; i < 300; i++) begin
      drive_bit(1, 1, 0);
      if (i == 7) exp_lock = 0;
      if (i == 254) chk("sat_errcnt_255", ecnt2, 8'hFF);
    end
    chk("sat_errcnt", ecnt2, 8'hFF);
    chk("sat_bitcnt", bcnt2, 8'hFF);
    drive_bit(1, 1, 1);
    chk("clr_err_errcnt", ecnt2, 0);
    chk("clr_err_bitcnt", bcnt2, 0);
    chk("clr_err_pulse", err2, 1);
    chk("clr_err_locked", locked2, 1);
    drive_bit(1, 1, 0);
    chk("post_clr_errcnt", ecnt2, 1);
    chk("post_clr_bitcnt", bcnt2, 1);

    #2;
    chk("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
